// File: rtl/frame_loader_pkg.sv
// ============================================================================
// frame_loader_pkg : shared frame geometry and FSM encoding for frame_loader
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_loader_pkg;

   localparam int DEF_CH    = 8;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_WIDTH = 8;

   localparam int DEF_RD_W  = $clog2(DEF_DEPTH);
   localparam int DEF_CH_W  = $clog2(DEF_CH);
   localparam int DEF_WR_W  = $clog2(DEF_CH * DEF_DEPTH);

   typedef enum logic [0:0] {
      LOAD   = 1'b0,
      STREAM = 1'b1
   } state_t;

endpackage : frame_loader_pkg

`default_nettype wire

// File: rtl/frame_loader_sample_ram.sv
// ============================================================================
// sample_ram : one channel of sample storage, sync write, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_ram
   import frame_loader_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_d;
   logic [WIDTH-1:0] rd_data_q;

   // Storage is never cleared; a fresh frame always overwrites it before use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register returns to zero whenever no word is being replayed.
   always_comb begin
      rd_data_d = '0;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule : sample_ram

`default_nettype wire

// File: rtl/frame_loader.sv
// ============================================================================
// frame_loader : byte-serial frame capture into per-channel RAM, then replay
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_loader
   import frame_loader_pkg::*;
#(
   parameter int CH    = DEF_CH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [CH*WIDTH-1:0] out_data,
   output logic                out_valid,
   output logic                out_last,
   output logic                busy
);

   localparam int RD_W = $clog2(DEPTH);
   localparam int CH_W = $clog2(CH);
   localparam int WR_W = $clog2(CH * DEPTH);

   localparam logic [WR_W-1:0] WR_LAST = WR_W'(CH * DEPTH - 1);
   localparam logic [RD_W-1:0] RD_LAST = RD_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [WR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [RD_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              wr_en;
   logic              rd_en;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               wr_en    = 1'b1;
               // Natural wrap of the byte pointer returns it to 0 after the last byte.
               wr_ptr_d = wr_ptr_q + WR_W'(1);
               if (wr_ptr_q == WR_LAST) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            rd_en       = 1'b1;
            out_valid_d = 1'b1;
            out_last_d  = (rd_ptr_q == RD_LAST);
            rd_ptr_d    = rd_ptr_q + RD_W'(1);
            if (rd_ptr_q == RD_LAST) begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Bytes arrive sample-major: low pointer bits pick the channel, high bits the sample.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      sample_ram #(
         .DEPTH (DEPTH),
         .WIDTH (WIDTH),
         .AW    (RD_W)
      ) u_ram (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en && (wr_ptr_q[CH_W-1:0] == CH_W'(c))),
         .wr_addr (wr_ptr_q[WR_W-1:CH_W]),
         .wr_data (in_data),
         .rd_en   (rd_en),
         .rd_addr (rd_ptr_q),
         .rd_data (out_data[c*WIDTH +: WIDTH])
      );
   end

   assign in_ready  = (state_q == LOAD);
   assign busy      = (state_q == STREAM);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule : frame_loader

`default_nettype wire

// File: doc/frame_loader.md
# frame_loader

Loads one frame of 8-channel, 32-sample, 8-bit data from a byte-serial valid/ready stream into on-chip sample memory, then replays the frame as 32 consecutive 8-channel words with a valid strobe. It is the writer/source end of the sample path: it replaces the reset-time file preload feeding the per-channel shift registers, and drives the `in_valid`/`in0..in7` inputs of `adder_tree` directly.

## Interface
Parameters:
- `CH`, 8, number of channels
- `DEPTH`, 32, samples per channel per frame
- `WIDTH`, 8, bits per sample

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  WIDTH  incoming sample byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts `in_data` this cycle
- `out_data`  out  CH*WIDTH  channel c in bits [c*WIDTH+WIDTH-1 : c*WIDTH]
- `out_valid`  out  1  `out_data` holds a frame sample word
- `out_last`  out  1  high with the final word (sample DEPTH-1) of a frame
- `busy`  out  1  high while in STREAM state

## Operation
- Two states: LOAD, STREAM. Reset state LOAD.
- Reset (async, immediate): state=LOAD, `wr_ptr`=0, `rd_ptr`=0, `out_data`=0, `out_valid`=0, `out_last`=0; `in_ready`=1 after reset release, `busy`=0. Memory contents not cleared (don't care).
- LOAD: `in_ready`=1. Byte accepted when `in_valid && in_ready` at a rising edge. Accepted byte k (0..CH*DEPTH-1, `wr_ptr`, 8 bits) is written to channel k mod CH, sample k div CH (sample-major order). `wr_ptr` increments per accepted byte; gaps in `in_valid` stall without effect.
- On acceptance of byte CH*DEPTH-1 (255): `wr_ptr`->0, state->STREAM.
- STREAM: `in_ready`=0; `in_valid` ignored, no write. Each edge: `out_data`<=word `rd_ptr` (all channels, sample `rd_ptr`), `out_valid`<=1, `out_last`<=(`rd_ptr`==DEPTH-1), `rd_ptr`++ (5-bit, wraps to 0). At the edge loading sample DEPTH-1, state->LOAD.
- In LOAD, `out_valid`, `out_last` <=0 each edge; `out_data` <=0.
- No backpressure on output: consumer must take every valid word.
- Overwrite safety: new-frame byte 0 may be accepted in the cycle `out_last` is high; sample 0 was already read, so it is legal.

## Timing
- Edge E accepts byte 255. Edges E+1..E+32 load samples 0..31; `out_valid` high for exactly 32 cycles following E+1; `out_last` high only in the cycle following E+32.
- `in_ready` low from after E until after E+32; earliest next accepted byte at edge E+33.
- Minimum frame period: 256 + 32 = 288 cycles with continuous `in_valid`.
- Read path: one registered stage from memory to `out_data`; no combinational path from `in_*` to `out_*`. `in_ready` is a decode of state only.
- Reset mid-LOAD or mid-STREAM aborts the frame; partial data is discarded (pointers zeroed), next frame restarts at byte 0.

## Structure
- Shared package: `CH`, `DEPTH`, `WIDTH`, derived pointer widths, state encoding (LOAD=0, STREAM=1).
- Sub-module `sample_ram`: one per channel, DEPTH x WIDTH, 1 synchronous write port, 1 synchronous read port (registered output doubles as `out_data` slice); instantiated CH times with write-enable decoded from `wr_ptr` low bits.
- Top holds FSM, `wr_ptr`, `rd_ptr`, output flags.

## Test plan
- Reset: assert `rst` mid-cycle -> all outputs 0 immediately, `in_ready`=1 after release, `busy`=0.
- Ramp frame: send bytes k=0..255 with `in_valid` continuous -> 32 `out_valid` cycles, word t = channel c value 8t+c; word 0 = 0x0706050403020100, word 31 = 0xFFFEFDFCFBFAF9F8 with `out_last`=1.
- Gapped input: `in_valid` toggled 1/0 every cycle over 256 bytes -> identical output to ramp, first `out_valid` one cycle after 256th accept.
- Input during STREAM: hold `in_valid`=1 with data 0xAA throughout -> `in_ready`=0 in STREAM, no byte consumed; next frame's byte 0 accepted at E+33 edge, second frame output correct.
- Back-to-back frames: ramp then inverted ramp (255-k) -> second frame word 0 = 0xF8F9FAFBFCFDFEFF, no corruption from overlap at `out_last`.
- Reset mid-frame: reset after 100 bytes, then full ramp -> output equals ramp frame; reset during STREAM word 10 -> `out_valid` drops immediately, no `out_last`.
